// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-ported memory.
// One access in flight: IDLE -> BUSY -> RESP -> IDLE, with starvation guard, timeout and fetch flush.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_err,
    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_LS_BUSY = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          discard_q, discard_d;
    logic          own_if_q, own_if_d;
    logic          wren_q, wren_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    bmask_q, bmask_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          if_win, ls_win;
    logic          busy, resp, if_rv, ls_rv;

    // Arbitration, access latching, completion capture and timeout.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        discard_d = discard_q;
        own_if_d  = own_if_q;
        wren_d    = wren_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bmask_d   = bmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if_win    = 1'b0;
        ls_win    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_if_req && (!i_ls_req || starve_q == SW'(STARVE_MAX))) begin
                    if_win = 1'b1;
                end else if (i_ls_req) begin
                    ls_win = 1'b1;
                end
                if (if_win) begin
                    state_d   = S_IF_BUSY;
                    own_if_d  = 1'b1;
                    wren_d    = 1'b0;
                    addr_d    = i_if_addr;
                    wdata_d   = '0;
                    bmask_d   = 4'hF;
                    starve_d  = '0;
                    tmo_d     = '0;
                    discard_d = i_if_flush;
                end else if (ls_win) begin
                    state_d   = S_LS_BUSY;
                    own_if_d  = 1'b0;
                    wren_d    = i_ls_wren;
                    addr_d    = i_ls_addr;
                    wdata_d   = i_ls_wdata;
                    bmask_d   = i_ls_bmask;
                    tmo_d     = '0;
                    discard_d = 1'b0;
                    if (i_if_req && starve_q != SW'(STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_IF_BUSY, S_LS_BUSY: begin
                tmo_d = tmo_q + TW'(1);
                if (state_q == S_IF_BUSY && i_if_flush) begin
                    discard_d = 1'b1;
                end
                // A late ack on the final cycle still beats the timeout.
                if (i_mem_ack) begin
                    state_d = S_RESP;
                    rdata_d = wren_q ? 32'h0 : i_mem_rdata;
                    err_d   = 1'b0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            starve_q  <= '0;
            tmo_q     <= '0;
            discard_q <= 1'b0;
            own_if_q  <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            discard_q <= discard_d;
            own_if_q  <= own_if_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bmask_q   <= bmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign busy  = (state_q == S_IF_BUSY) || (state_q == S_LS_BUSY);
    assign resp  = (state_q == S_RESP);
    assign if_rv = resp && own_if_q && !discard_q;
    assign ls_rv = resp && !own_if_q;

    // Grants are combinational, so they are gated to stay quiet while reset is held.
    assign o_if_gnt    = i_reset && if_win;
    assign o_ls_gnt    = i_reset && ls_win;
    assign o_mem_req   = busy;
    assign o_mem_wren  = busy && wren_q;
    assign o_mem_addr  = busy ? addr_q  : 32'h0;
    assign o_mem_wdata = busy ? wdata_q : 32'h0;
    assign o_mem_bmask = busy ? bmask_q : 4'h0;
    assign o_if_rvalid = if_rv;
    assign o_if_rdata  = if_rv ? rdata_q : 32'h0;
    assign o_if_err    = if_rv && err_q;
    assign o_ls_rvalid = ls_rv;
    assign o_ls_rdata  = ls_rv ? rdata_q : 32'h0;
    assign o_ls_err    = ls_rv && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and random traffic
// compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned TIMEOUT    = 16;

    logic        i_clk, i_reset;
    logic        i_if_req, i_if_flush, i_ls_req, i_ls_wren, i_mem_ack;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_bmask;
    logic        o_if_gnt, o_if_rvalid, o_if_err, o_ls_gnt, o_ls_rvalid, o_ls_err;
    logic        o_mem_req, o_mem_wren;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
        .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
        .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
        .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        flush;
        logic        ls_req;
        logic        ls_wren;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_bmask;
        logic        ack;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        ls_gnt;
        logic        mem_req;
        logic        mem_wren;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_bmask;
        logic        if_rv;
        logic [31:0] if_rd;
        logic        if_err;
        logic        ls_rv;
        logic [31:0] ls_rd;
        logic        ls_err;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t want;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t w);
        chk({tag, " if_gnt"},    32'(o_if_gnt),    32'(w.if_gnt));
        chk({tag, " ls_gnt"},    32'(o_ls_gnt),    32'(w.ls_gnt));
        chk({tag, " mem_req"},   32'(o_mem_req),   32'(w.mem_req));
        chk({tag, " mem_wren"},  32'(o_mem_wren),  32'(w.mem_wren));
        chk({tag, " mem_addr"},  o_mem_addr,       w.mem_addr);
        chk({tag, " mem_wdata"}, o_mem_wdata,      w.mem_wdata);
        chk({tag, " mem_bmask"}, 32'(o_mem_bmask), 32'(w.mem_bmask));
        chk({tag, " if_rvalid"}, 32'(o_if_rvalid), 32'(w.if_rv));
        chk({tag, " if_rdata"},  o_if_rdata,       w.if_rd);
        chk({tag, " if_err"},    32'(o_if_err),    32'(w.if_err));
        chk({tag, " ls_rvalid"}, 32'(o_ls_rvalid), 32'(w.ls_rv));
        chk({tag, " ls_rdata"},  o_ls_rdata,       w.ls_rd);
        chk({tag, " ls_err"},    32'(o_ls_err),    32'(w.ls_err));
    endtask

    function automatic in_t fin(input logic ifr, input logic [31:0] ifa, input logic fl,
                                input logic lsr, input logic lsw, input logic [31:0] lsa,
                                input logic [31:0] lswd, input logic [3:0] lsb,
                                input logic ack, input logic [31:0] mrd);
        in_t s;
        s.if_req = ifr; s.if_addr = ifa; s.flush = fl;
        s.ls_req = lsr; s.ls_wren = lsw; s.ls_addr = lsa; s.ls_wdata = lswd; s.ls_bmask = lsb;
        s.ack = ack; s.mrd = mrd;
        return s;
    endfunction

    function automatic in_t fidle();
        return fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endfunction

    function automatic out_t o_none();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_ifg();
        out_t o;
        o = '0; o.if_gnt = 1'b1;
        return o;
    endfunction

    function automatic out_t o_lsg();
        out_t o;
        o = '0; o.ls_gnt = 1'b1;
        return o;
    endfunction

    function automatic out_t o_busy(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] b);
        out_t o;
        o = '0; o.mem_req = 1'b1; o.mem_wren = w; o.mem_addr = a; o.mem_wdata = d; o.mem_bmask = b;
        return o;
    endfunction

    function automatic out_t o_ifrv(input logic [31:0] d, input logic e);
        out_t o;
        o = '0; o.if_rv = 1'b1; o.if_rd = d; o.if_err = e;
        return o;
    endfunction

    function automatic out_t o_lsrv(input logic [31:0] d, input logic e);
        out_t o;
        o = '0; o.ls_rv = 1'b1; o.ls_rd = d; o.ls_err = e;
        return o;
    endfunction

    task automatic drive(input in_t s);
        i_if_req = s.if_req; i_if_addr = s.if_addr; i_if_flush = s.flush;
        i_ls_req = s.ls_req; i_ls_wren = s.ls_wren; i_ls_addr = s.ls_addr;
        i_ls_wdata = s.ls_wdata; i_ls_bmask = s.ls_bmask;
        i_mem_ack = s.ack; i_mem_rdata = s.mrd;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        drive(fidle());
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    // Transaction-level reference: one access record, its wait age, and the starvation tally.
    logic        m_active, m_done, m_if, m_wren, m_discard, m_err;
    logic [31:0] m_addr, m_wdata, m_data;
    logic [3:0]  m_bmask;
    int unsigned m_wait, m_starve;

    task automatic model_clear();
        m_active = 1'b0; m_done = 1'b0; m_if = 1'b0; m_wren = 1'b0; m_discard = 1'b0;
        m_err = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_data = 32'h0; m_bmask = 4'h0;
        m_wait = 0; m_starve = 0;
    endtask

    function automatic out_t model_out(input in_t s);
        out_t o;
        o = '0;
        if (!m_active) begin
            if (s.if_req && s.ls_req) begin
                if (m_starve == STARVE_MAX) o.if_gnt = 1'b1;
                else                        o.ls_gnt = 1'b1;
            end else begin
                o.if_gnt = s.if_req;
                o.ls_gnt = s.ls_req;
            end
        end else if (!m_done) begin
            o = o_busy(m_wren, m_addr, m_wdata, m_bmask);
        end else if (m_if) begin
            if (!m_discard) o = o_ifrv(m_data, m_err);
        end else begin
            o = o_lsrv(m_data, m_err);
        end
        return o;
    endfunction

    task automatic model_step(input in_t s, input out_t o);
        if (!m_active) begin
            if (o.if_gnt) begin
                m_active = 1'b1; m_done = 1'b0; m_if = 1'b1; m_wren = 1'b0; m_addr = s.if_addr;
                m_wdata = 32'h0; m_bmask = 4'hF; m_wait = 0; m_discard = s.flush; m_starve = 0;
            end else if (o.ls_gnt) begin
                m_active = 1'b1; m_done = 1'b0; m_if = 1'b0; m_wren = s.ls_wren; m_addr = s.ls_addr;
                m_wdata = s.ls_wdata; m_bmask = s.ls_bmask; m_wait = 0; m_discard = 1'b0;
                if (s.if_req && m_starve < STARVE_MAX) m_starve = m_starve + 1;
            end
        end else if (!m_done) begin
            m_wait = m_wait + 1;
            if (m_if && s.flush) m_discard = 1'b1;
            if (s.ack) begin
                m_done = 1'b1; m_data = m_wren ? 32'h0 : s.mrd; m_err = 1'b0;
            end else if (m_wait == TIMEOUT) begin
                m_done = 1'b1; m_data = 32'h0; m_err = 1'b1;
            end
        end else begin
            m_active = 1'b0; m_discard = 1'b0;
        end
    endtask

    vec_t vt[21];
    int   got[10];
    int   exp_order[10];
    int   ngnt, nboth;

    initial begin
        vt[0]  = '{fin(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0), o_ifg()};
        vt[1]  = '{fin(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 1, 32'h0050_0093), o_busy(0, 32'h100, 0, 4'hF)};
        vt[2]  = '{fidle(), o_ifrv(32'h0050_0093, 0)};
        vt[3]  = '{fin(0, 0, 0, 1, 1, 32'h7000, 32'hDEAD_BEEF, 4'b0011, 0, 0), o_lsg()};
        vt[4]  = '{fin(0, 0, 0, 0, 0, 32'h1234, 32'h0, 4'hC, 0, 32'h5555_5555),
                   o_busy(1, 32'h7000, 32'hDEAD_BEEF, 4'b0011)};
        vt[5]  = '{fin(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678), o_busy(1, 32'h7000, 32'hDEAD_BEEF, 4'b0011)};
        vt[6]  = '{fidle(), o_lsrv(32'h0, 0)};
        vt[7]  = '{fidle(), o_none()};
        vt[8]  = '{fin(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0), o_ifg()};
        vt[9]  = '{fin(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), o_busy(0, 32'h200, 0, 4'hF)};
        vt[10] = '{fin(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555), o_busy(0, 32'h200, 0, 4'hF)};
        vt[11] = '{fidle(), o_none()};
        vt[12] = '{fin(1, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0), o_ifg()};
        vt[13] = '{fin(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222), o_busy(0, 32'h204, 0, 4'hF)};
        vt[14] = '{fidle(), o_ifrv(32'h1111_2222, 0)};
        vt[15] = '{fin(0, 0, 1, 1, 0, 32'h40, 32'h0, 4'hF, 0, 0), o_lsg()};
        vt[16] = '{fin(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D), o_busy(0, 32'h40, 0, 4'hF)};
        vt[17] = '{fin(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), o_lsrv(32'h0BAD_F00D, 0)};
        vt[18] = '{fin(1, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0), o_ifg()};
        vt[19] = '{fin(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_8888), o_busy(0, 32'h300, 0, 4'hF)};
        vt[20] = '{fidle(), o_none()};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset with both requesters active: every output must stay low.
        i_reset = 1'b0;
        drive(fin(1, 32'h10, 1, 1, 1, 32'h20, 32'h30, 4'hF, 1, 32'h40));
        #1;
        cmp_out("reset", o_none());

        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge i_clk);
            drive(vt[i].stim);
            #1;
            cmp_out($sformatf("vec%0d", i), vt[i].want);
        end

        // Both requesters held high with immediate acks.
        do_reset();
        ngnt = 0; nboth = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            drive(fin(1, 32'h1000, 0, 1, 0, 32'h2000, 32'h0, 4'hF, 1, 32'h1));
            #1;
            if (o_if_gnt && o_ls_gnt) nboth++;
            if (o_if_gnt || o_ls_gnt) begin
                if (ngnt < 10) got[ngnt] = o_if_gnt ? 1 : 0;
                ngnt++;
            end
        end
        chk("contention grant_count", 32'(ngnt), 32'd10);
        chk("contention double_grant", 32'(nboth), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("contention order%0d (1=IF)", i), 32'(got[i]), 32'(exp_order[i]));
        end

        // Load that never sees an ack, then one acked on the last allowed cycle.
        do_reset();
        @(negedge i_clk);
        drive(fin(0, 0, 0, 1, 0, 32'h500, 32'h0, 4'hF, 0, 0));
        #1; cmp_out("to_gnt", o_lsg());
        for (int b = 1; b <= 16; b++) begin
            @(negedge i_clk);
            drive(fin(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
            #1; cmp_out($sformatf("to_busy%0d", b), o_busy(0, 32'h500, 0, 4'hF));
        end
        @(negedge i_clk);
        drive(fidle());
        #1; cmp_out("to_resp", o_lsrv(32'h0, 1));
        @(negedge i_clk);
        drive(fin(0, 0, 0, 1, 0, 32'h504, 32'h0, 4'hF, 0, 0));
        #1; cmp_out("to_idle_gnt", o_lsg());
        for (int b = 1; b <= 16; b++) begin
            @(negedge i_clk);
            drive(fin(0, 0, 0, 0, 0, 0, 0, 0, (b == 16), 32'hCAFE_F00D));
            #1; cmp_out($sformatf("ack16_busy%0d", b), o_busy(0, 32'h504, 0, 4'hF));
        end
        @(negedge i_clk);
        drive(fidle());
        #1; cmp_out("ack16_resp", o_lsrv(32'hCAFE_F00D, 0));

        // Reset dropped in the middle of a load.
        do_reset();
        @(negedge i_clk);
        drive(fin(0, 0, 0, 1, 0, 32'h900, 32'h0, 4'hF, 0, 0));
        #1; cmp_out("rst_gnt", o_lsg());
        @(negedge i_clk);
        drive(fidle());
        #1; cmp_out("rst_busy", o_busy(0, 32'h900, 0, 4'hF));
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(fin(1, 32'h10, 0, 1, 0, 32'h20, 32'h0, 4'hF, 1, 32'h1));
        #1; cmp_out("rst_async", o_none());
        repeat (2) begin
            @(negedge i_clk);
            #1; cmp_out("rst_hold", o_none());
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        drive(fin(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1));
        for (int c = 0; c < 5; c++) begin
            #1; cmp_out($sformatf("rst_after%0d", c), o_none());
            @(negedge i_clk);
        end

        // Random traffic with periodic memory stalls long enough to force timeouts.
        do_reset();
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            in_t  s;
            out_t w;
            s.if_req   = 1'($urandom_range(0, 1));
            s.if_addr  = $urandom();
            s.flush    = ($urandom_range(0, 7) == 0);
            s.ls_req   = 1'($urandom_range(0, 1));
            s.ls_wren  = 1'($urandom_range(0, 1));
            s.ls_addr  = $urandom();
            s.ls_wdata = $urandom();
            s.ls_bmask = 4'($urandom_range(0, 15));
            s.ack      = (((n / 64) % 4) != 3) && ($urandom_range(0, 3) == 0);
            s.mrd      = $urandom();
            @(negedge i_clk);
            drive(s);
            #1;
            w = model_out(s);
            cmp_out($sformatf("rnd%0d", n), w);
            model_step(s, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
